// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry frame monitor.
// Optional trend feature in the top is enabled with `TELEM_TREND_EN.
package telem_pkg;

  typedef enum logic [1:0] {
    HUNT1,
    HUNT2,
    PAY_HI,
    PAY_LO
  } state_t;

  localparam logic [7:0] DEF_DELIM1   = 8'hAA;
  localparam logic [7:0] DEF_DELIM2   = 8'h55;
  localparam int         BYTES_PER_CH = 2;
  localparam int         ERR_W        = 8;
  localparam int         CNT_W        = 16;

endpackage

// File: rtl/telem_frame_mon_if.sv
// Byte handshake between a UART receiver (master) and the frame monitor (slave).
interface telem_frame_mon_if;

  logic       rdy;
  logic [7:0] rx_data;
  logic       clr_rdy;

  modport master (output rdy, output rx_data, input clr_rdy);
  modport slave  (input rdy, input rx_data, output clr_rdy);

endinterface

// File: rtl/telem_byte_if.sv
// Byte acceptance (rdy/clr_rdy) and inter-byte idle timeout for the frame monitor.
module telem_byte_if #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst,
  telem_frame_mon_if.slave   bus,
  input  logic               cnt_en,
  output logic               byte_vld,
  output logic [7:0]         rx_byte,
  output logic               timeout
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // rdy is still high while clr_rdy is out; masking it stops a double consume.
  assign byte_vld = bus.rdy && !bus.clr_rdy;
  assign rx_byte  = bus.rx_data;
  assign timeout  = cnt_en && !byte_vld && (idle_cnt == IDLE_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.clr_rdy <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      bus.clr_rdy <= byte_vld;
      if (!cnt_en || byte_vld || timeout) idle_cnt <= '0;
      else                                idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/telem_frame_mon.sv
// Telemetry frame decoder: delimiter hunt, channel assembly, frame/error counters.
// Define TELEM_TREND_EN to enable per-channel rising/falling trend flags.
module telem_frame_mon
  import telem_pkg::*;
#(
  parameter int         NUM_CH      = 3,
  parameter int         CH_W        = 12,
  parameter logic [7:0] DELIM1      = DEF_DELIM1,
  parameter logic [7:0] DELIM2      = DEF_DELIM2,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         TREND_HYST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  telem_frame_mon_if.slave       bus,
  output logic [NUM_CH*CH_W-1:0] ch_data,
  output logic                   frm_vld,
  output logic [CNT_W-1:0]       frm_cnt,
  output logic [ERR_W-1:0]       sync_err,
  output logic [NUM_CH-1:0]      ch_up,
  output logic [NUM_CH-1:0]      ch_dn
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WORD_W = BYTES_PER_CH * 8;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  state_t                     state;
  logic [IDX_W-1:0]           ch_idx;
  logic [WORD_W-1:0]          shadow [NUM_CH];
  logic                       byte_vld;
  logic                       timeout;
  logic [7:0]                 rx_byte;
  logic                       frame_done;
  logic                       err_pulse;
  logic [WORD_W-1:0]          last_word;
  logic [NUM_CH*CH_W-1:0]     frame_next;

  telem_byte_if #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_byte_if (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cnt_en   (state != HUNT1),
    .byte_vld (byte_vld),
    .rx_byte  (rx_byte),
    .timeout  (timeout)
  );

  assign frame_done = byte_vld && (state == PAY_LO) && (ch_idx == LAST_CH);
  assign err_pulse  = timeout ||
                      (byte_vld && (state == HUNT2) && (rx_byte != DELIM2) && (rx_byte != DELIM1));
  // Final channel merges the low byte arriving this cycle so the frame lands atomically.
  assign last_word  = {shadow[NUM_CH-1][WORD_W-1:8], rx_byte};

  // NOTE: give every always_comb output a default first; a missed branch would infer a latch.
  always_comb begin
    frame_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      frame_next[i*CH_W +: CH_W] = (i == NUM_CH - 1) ? last_word[CH_W-1:0] : shadow[i][CH_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT1;
      ch_idx   <= '0;
      // NOTE: shadow is a handful of flops, so it is cleared here; a RAM-backed array would not be.
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      ch_data  <= '0;
      frm_vld  <= 1'b0;
      frm_cnt  <= '0;
      sync_err <= '0;
    end else begin
      frm_vld <= frame_done;
      if (frame_done) begin
        ch_data <= frame_next;
        frm_cnt <= frm_cnt + 1'b1;
      end
      if (err_pulse && (sync_err != '1)) sync_err <= sync_err + 1'b1;

      if (timeout) begin
        state <= HUNT1;
      end else if (byte_vld) begin
        case (state)
          HUNT1: if (rx_byte == DELIM1) state <= HUNT2;
          HUNT2: begin
            if (rx_byte == DELIM2) begin
              state  <= PAY_HI;
              ch_idx <= '0;
            end else if (rx_byte != DELIM1) begin
              state <= HUNT1;
            end
          end
          PAY_HI: begin
            shadow[ch_idx][WORD_W-1:8] <= rx_byte;
            state                      <= PAY_LO;
          end
          PAY_LO: begin
            shadow[ch_idx][7:0] <= rx_byte;
            if (ch_idx == LAST_CH) begin
              state <= HUNT1;
            end else begin
              ch_idx <= ch_idx + 1'b1;
              state  <= PAY_HI;
            end
          end
          default: state <= HUNT1;
        endcase
      end
    end
  end

`ifdef TELEM_TREND_EN
  localparam logic [CH_W:0] HYST_EXT = (CH_W + 1)'(TREND_HYST);

  logic [CH_W-1:0] prev_data [NUM_CH];
  logic            have_prev;

  // Compare one bit wider than a channel so prev+HYST cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) prev_data[i] <= '0;
      have_prev <= 1'b0;
      ch_up     <= '0;
      ch_dn     <= '0;
    end else if (frame_done) begin
      have_prev <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        prev_data[i] <= frame_next[i*CH_W +: CH_W];
        ch_up[i] <= have_prev &&
                    ({1'b0, frame_next[i*CH_W +: CH_W]} > ({1'b0, prev_data[i]} + HYST_EXT));
        ch_dn[i] <= have_prev &&
                    (({1'b0, frame_next[i*CH_W +: CH_W]} + HYST_EXT) < {1'b0, prev_data[i]});
      end
    end
  end
`else
  assign ch_up = '0;
  assign ch_dn = '0;
`endif

endmodule

// File: tb/tb_telem_frame_mon.sv
// Scoreboard bench for telem_frame_mon: directed cases plus randomized frames/junk/timeouts.
module tb_telem_frame_mon;
  import telem_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 12;
  localparam int TOUT   = 32;
  localparam int HYST   = 4;
  localparam int W      = NUM_CH * CH_W;
  localparam int NBYTES = NUM_CH * BYTES_PER_CH;

  typedef struct {
    logic [W-1:0]      data;
    logic [CNT_W-1:0]  cnt;
    logic [ERR_W-1:0]  err;
    logic [NUM_CH-1:0] up;
    logic [NUM_CH-1:0] dn;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0]      ch_data;
  logic              frm_vld;
  logic [CNT_W-1:0]  frm_cnt;
  logic [ERR_W-1:0]  sync_err;
  logic [NUM_CH-1:0] ch_up;
  logic [NUM_CH-1:0] ch_dn;

  telem_frame_mon_if bus ();

  telem_frame_mon #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .TIMEOUT_CYC (TOUT),
    .TREND_HYST  (HYST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ch_data  (ch_data),
    .frm_vld  (frm_vld),
    .frm_cnt  (frm_cnt),
    .sync_err (sync_err),
    .ch_up    (ch_up),
    .ch_dn    (ch_dn)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_sent   = 0;
  int n_clr    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte position in the frame (-2 = waiting for first delimiter,
  // -1 = waiting for second, 0.. = payload byte number) plus the payload collected so far.
  int                pos;
  logic [7:0]        pay [NBYTES];
  logic [W-1:0]      exp_data;
  int                exp_cnt;
  int                exp_err;
  logic [CH_W-1:0]   prev_val [NUM_CH];
  bit                have_prev;
  logic [NUM_CH-1:0] exp_up;
  logic [NUM_CH-1:0] exp_dn;
  frame_t            exp_q [$];
  frame_t            mon_item;

  function automatic void model_reset();
    pos       = -2;
    exp_data  = '0;
    exp_cnt   = 0;
    exp_err   = 0;
    have_prev = 0;
    exp_up    = '0;
    exp_dn    = '0;
    exp_q.delete();
  endfunction

  function automatic void model_err();
    if (exp_err < 255) exp_err++;
  endfunction

  function automatic void model_timeout();
    if (pos != -2) begin
      model_err();
      pos = -2;
    end
  endfunction

  function automatic void model_frame();
    frame_t  f;
    int      val;
    for (int i = 0; i < NUM_CH; i++) begin
      val = ((int'(pay[2*i]) * 256) + int'(pay[2*i+1])) % (1 << CH_W);
      exp_data[i*CH_W +: CH_W] = CH_W'(val);
`ifdef TELEM_TREND_EN
      exp_up[i] = have_prev && (val > int'(prev_val[i]) + HYST);
      exp_dn[i] = have_prev && (val + HYST < int'(prev_val[i]));
`else
      exp_up[i] = 1'b0;
      exp_dn[i] = 1'b0;
`endif
      prev_val[i] = CH_W'(val);
    end
    have_prev = 1;
    exp_cnt   = (exp_cnt + 1) % 65536;
    f.data = exp_data;
    f.cnt  = CNT_W'(exp_cnt);
    f.err  = ERR_W'(exp_err);
    f.up   = exp_up;
    f.dn   = exp_dn;
    exp_q.push_back(f);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (pos == -2) begin
      if (b == DEF_DELIM1) pos = -1;
    end else if (pos == -1) begin
      if (b == DEF_DELIM2) pos = 0;
      else if (b != DEF_DELIM1) begin
        model_err();
        pos = -2;
      end
    end else begin
      pay[pos] = b;
      pos++;
      if (pos == NBYTES) begin
        model_frame();
        pos = -2;
      end
    end
  endfunction

  // Monitor: every frm_vld pops one expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.clr_rdy) n_clr++;
      if (frm_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected frm_vld", frm_vld, 1'b0);
        end else begin
          mon_item = exp_q.pop_front();
          check("frame ch_data",  ch_data,  mon_item.data);
          check("frame frm_cnt",  frm_cnt,  mon_item.cnt);
          check("frame sync_err", sync_err, mon_item.err);
          check("frame ch_up",    ch_up,    mon_item.up);
          check("frame ch_dn",    ch_dn,    mon_item.dn);
        end
      end
    end
  end

  // gap = idle cycles before rdy rises; accept-to-accept distance is gap+2.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit seen;
    if (gap + 2 > TOUT) model_timeout();
    if (gap > 0) bus.rdy = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rdy     = 1'b1;
    bus.rx_data = b;
    seen = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      seen = bus.clr_rdy;
    end
    check("byte accepted", seen, 1'b1);
    n_sent++;
    model_byte(b);
    @(negedge clk);
    check("rdy during clr_rdy not re-consumed", bus.clr_rdy, 1'b0);
    bus.rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] vals, input int long_at);
    logic [15:0] w;
    int          gap;
    send_byte(DEF_DELIM1, $urandom_range(0, 3));
    send_byte(DEF_DELIM2, $urandom_range(0, 3));
    for (int i = 0; i < NUM_CH; i++) begin
      w = 16'($urandom);
      w[CH_W-1:0] = vals[i*CH_W +: CH_W];
      gap = (long_at == 2*i) ? TOUT + 6 : $urandom_range(0, 3);
      send_byte(w[15:8], gap);
      gap = (long_at == 2*i+1) ? TOUT + 6 : $urandom_range(0, 3);
      send_byte(w[7:0], gap);
    end
  endtask

  task automatic idle_long();
    model_timeout();
    bus.rdy = 1'b0;
    repeat (TOUT + 8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.rdy = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check("reset ch_data",  ch_data,     '0);
    check("reset frm_vld",  frm_vld,     1'b0);
    check("reset frm_cnt",  frm_cnt,     '0);
    check("reset sync_err", sync_err,    '0);
    check("reset clr_rdy",  bus.clr_rdy, 1'b0);
    check("reset ch_up",    ch_up,       '0);
    check("reset ch_dn",    ch_dn,       '0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] t1 [8];
  logic [W-1:0] vals;
  int r;

  initial begin
    rst         = 1'b1;
    bus.rdy     = 1'b0;
    bus.rx_data = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset();

    // Basic frame with known channel values.
    t1 = '{8'hAA, 8'h55, 8'h0B, 8'hFF, 8'h07, 8'h00, 8'h09, 8'h00};
    foreach (t1[i]) send_byte(t1[i], 0);
    repeat (2) @(negedge clk);
    check("t1 ch_data", ch_data, 36'h900_700_BFF);
    check("t1 frm_cnt", frm_cnt, 16'd1);

    // Repeated first delimiter then a good frame; then a bad second delimiter.
    send_byte(8'hAA, 1);
    send_frame({12'h123, 12'h456, 12'h789}, -1);
    repeat (2) @(negedge clk);
    check("t2 sync_err after AA AA 55", sync_err, 8'd0);
    check("t2 frm_cnt", frm_cnt, 16'd2);
    send_byte(8'hAA, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    check("t2 sync_err after AA 12", sync_err, 8'd1);

    // Delimiter values used as payload bytes.
    t1 = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'h55, 8'hAA, 8'hAA, 8'hAA};
    foreach (t1[i]) send_byte(t1[i], 0);
    repeat (2) @(negedge clk);
    check("delim-as-data ch_data", ch_data, 36'hAAA_5AA_A55);

    // Partial frame then long idle: timeout error, ch_data held.
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'h0B, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    idle_long();
    check("t3 sync_err after timeout", sync_err, 8'd2);
    check("t3 ch_data held", ch_data, 36'hAAA_5AA_A55);
    send_frame({12'h00F, 12'hF00, 12'h0F0}, -1);

    // Gap well inside the timeout window does not abort the frame.
    send_frame({12'h321, 12'h654, 12'h987}, 3);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    for (int i = 0; i < NBYTES; i++) send_byte(8'(i + 1), (i == 2) ? TOUT - 4 : 0);
    repeat (2) @(negedge clk);
    check("near-timeout gap no error", sync_err, 8'(exp_err));

    // Reset mid-frame, then a clean frame with no stale bytes.
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'h0B, 0);
    do_reset();
    send_frame({12'h111, 12'h222, 12'h333}, -1);
    repeat (2) @(negedge clk);
    check("t4 frm_cnt after reset", frm_cnt, 16'd1);
    check("t4 ch_data", ch_data, 36'h111_222_333);

    // Trend sequence on ch0.
    send_frame({12'h050, 12'h050, 12'h100}, -1);
    send_frame({12'h050, 12'h050, 12'h110}, -1);
    repeat (2) @(negedge clk);
    check("t6 ch_up[0] after 100->110", ch_up[0], exp_up[0]);
    send_frame({12'h050, 12'h050, 12'h10E}, -1);
    repeat (2) @(negedge clk);
    check("t6 ch_up[0] within hyst", ch_up[0], 1'b0);
    check("t6 ch_dn[0] within hyst", ch_dn[0], 1'b0);

    // Randomized frames, junk bytes and occasional timeouts.
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(0, 9);
      vals = {12'($urandom), 12'($urandom), 12'($urandom)};
      if (r < 6)       send_frame(vals, -1);
      else if (r == 6) send_frame(vals, $urandom_range(0, NBYTES - 1));
      else begin
        for (int j = 0; j < $urandom_range(1, 3); j++)
          send_byte(($urandom_range(0, 2) == 0) ? DEF_DELIM1 : 8'($urandom), $urandom_range(0, 2));
      end
    end
    idle_long();

    check("final frm_cnt", frm_cnt, 16'(exp_cnt));
    check("final sync_err", sync_err, 8'(exp_err));
    check("final ch_data", ch_data, exp_data);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    check("one clr_rdy per byte", 64'(n_clr), 64'(n_sent));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global time limit: got timeout, expected completion");
    $fatal(1);
  end

endmodule
